nand_universal_reg: RTL and testbench

//   Parametrised WIDTH-bit register with hold, parallel-load, shift-left and count-up modes.

---
 rtl/nand_universal_reg.sv | 121 ++++++++++++
 tb/tb_nand_universal_reg.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/nand_universal_reg.sv
// WIDTH-bit hold/load/shift-left/count register built from NAND gates and clear-only flops.
// Bits whose reset value is 1 store their inverse so only clear-type flops are needed.

module nand_universal_reg_dff (
    input  logic C,
    input  logic R,
    input  logic d,
    output logic q
);
    always_ff @(posedge C or posedge R) begin
        if (R) q <= 1'b0;
        else   q <= d;
    end
endmodule

module nand_universal_reg_bit #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic C,
    input  logic R,
    input  logic hold,
    input  logic load,
    input  logic shl,
    input  logic cnt,
    input  logic d,
    input  logic s,
    input  logic t,
    output logic q
);
    logic a, x_l, x_r, tq;
    logic h_n, l_n, s_n, c_n, nxt;
    logic ff_d, ff_q;

    // q ^ t from four NANDs
    assign a   = ~(q & t);
    assign x_l = ~(q & a);
    assign x_r = ~(t & a);
    assign tq  = ~(x_l & x_r);

    assign h_n = ~(hold & q);
    assign l_n = ~(load & d);
    assign s_n = ~(shl & s);
    assign c_n = ~(cnt & tq);
    assign nxt = ~(h_n & l_n & s_n & c_n);

    generate
        if (RST_BIT) begin : g_inv
            assign ff_d = ~(nxt & nxt);
            assign q    = ~(ff_q & ff_q);
        end else begin : g_pass
            assign ff_d = nxt;
            assign q    = ff_q;
        end
    endgenerate

    nand_universal_reg_dff u_ff (.C(C), .R(R), .d(ff_d), .q(ff_q));
endmodule

module nand_universal_reg #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             C,
    input  logic             R,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             CO
);
    logic m1_n, m0_n;
    logic load_n, shl_n, cnt_n, upd;
    logic hold, load, shl, cnt;
    logic [WIDTH:0] t;
    logic [WIDTH:0] t_n;
    logic co_n;

    // Active-low mode decode, each term already qualified by EN
    assign m1_n   = ~(MODE[1] & MODE[1]);
    assign m0_n   = ~(MODE[0] & MODE[0]);
    assign load_n = ~(EN & m1_n & MODE[0]);
    assign shl_n  = ~(EN & MODE[1] & m0_n);
    assign cnt_n  = ~(EN & MODE[1] & MODE[0]);
    assign upd    = ~(load_n & shl_n & cnt_n);

    assign hold = ~(upd & upd);
    assign load = ~(load_n & load_n);
    assign shl  = ~(shl_n & shl_n);
    assign cnt  = ~(cnt_n & cnt_n);

    assign t_n[0] = 1'b0;
    assign t[0]   = 1'b1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            // t[i+1] = &Q[i:0], formed as a wide NAND plus inverter
            assign t_n[i+1] = ~(&Q[i:0]);
            assign t[i+1]   = ~(t_n[i+1] & t_n[i+1]);

            nand_universal_reg_bit #(.RST_BIT(RESET_VALUE[i])) u_bit (
                .C    (C),
                .R    (R),
                .hold (hold),
                .load (load),
                .shl  (shl),
                .cnt  (cnt),
                .d    (D[i]),
                .s    ((i == 0) ? SI : Q[(i == 0) ? 0 : i-1]),
                .t    (t[i]),
                .q    (Q[i])
            );
        end
    endgenerate

    assign SO   = Q[WIDTH-1];
    assign co_n = ~(cnt & t[WIDTH]);
    assign CO   = ~(co_n & co_n);
endmodule

// File: tb/tb_nand_universal_reg.sv
// Scoreboard bench: a WIDTH=8/A5 and a WIDTH=1/1 instance run in lockstep against an arithmetic model.

module tb_nand_universal_reg;
    localparam logic [1:0] HOLD = 2'd0, LOAD = 2'd1, SHL = 2'd2, CNT = 2'd3;

    typedef struct {
        logic       r;
        logic       en;
        logic [1:0] mode;
        logic [7:0] d;
        logic       si;
    } stim_t;

    typedef struct {
        logic [7:0] q8;
        logic       so8, co8;
        logic       q1, so1, co1;
    } exp_t;

    logic       C = 1'b0;
    logic       r8 = 1'b1, en8 = 1'b0, si8 = 1'b0;
    logic [1:0] mode8 = 2'd0;
    logic [7:0] d8 = 8'h00;
    logic [7:0] q8;
    logic       so8, co8;
    logic       r1 = 1'b1, en1 = 1'b0, si1 = 1'b0;
    logic [1:0] mode1 = 2'd0;
    logic [0:0] d1 = 1'b0;
    logic [0:0] q1;
    logic       so1, co1;

    nand_universal_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
        .C(C), .R(r8), .EN(en8), .MODE(mode8), .D(d8), .SI(si8),
        .Q(q8), .SO(so8), .CO(co8)
    );

    nand_universal_reg #(.WIDTH(1), .RESET_VALUE(1'b1)) dut1 (
        .C(C), .R(r1), .EN(en1), .MODE(mode1), .D(d1), .SI(si1),
        .Q(q1), .SO(so1), .CO(co1)
    );

    always #5 C = ~C;

    exp_t       sb[$];
    int         total = 0;
    int         passed = 0;
    logic [7:0] m8 = 8'hA5;
    logic [7:0] m1 = 8'h01;

    function automatic logic [7:0] mnext(logic [7:0] q, int w, stim_t s);
        int mask;
        int v;
        mask = (1 << w) - 1;
        v = int'(q);
        if (s.en) begin
            case (s.mode)
                LOAD:    v = int'(s.d);
                SHL:     v = (int'(q) * 2) + int'(s.si);
                CNT:     v = int'(q) + 1;
                default: v = int'(q);
            endcase
        end
        return 8'(v & mask);
    endfunction

    function automatic stim_t mk(logic r, logic en, logic [1:0] mode, logic [7:0] d, logic si);
        stim_t s;
        s.r = r; s.en = en; s.mode = mode; s.d = d; s.si = si;
        return s;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle's inputs just after an edge, queue what the outputs must
    // show during that cycle, then advance the model across the next edge.
    task automatic step(input stim_t a, input stim_t b);
        exp_t e;
        r8 = a.r; en8 = a.en; mode8 = a.mode; d8 = a.d; si8 = a.si;
        r1 = b.r; en1 = b.en; mode1 = b.mode; d1 = b.d[0]; si1 = b.si;
        if (a.r) m8 = 8'hA5;
        if (b.r) m1 = 8'h01;
        e.q8  = m8;
        e.so8 = m8[7];
        e.co8 = a.en && (a.mode == CNT) && (m8 == 8'hFF);
        e.q1  = m1[0];
        e.so1 = m1[0];
        e.co1 = b.en && (b.mode == CNT) && (m1[0] == 1'b1);
        sb.push_back(e);
        @(posedge C);
        if (!a.r) m8 = mnext(m8, 8, a);
        if (!b.r) m1 = mnext(m1, 1, b);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge C);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q8",  q8,        e.q8);
                chk("so8", {7'd0, so8}, {7'd0, e.so8});
                chk("co8", {7'd0, co8}, {7'd0, e.co8});
                chk("q1",  {7'd0, q1},  {7'd0, e.q1});
                chk("so1", {7'd0, so1}, {7'd0, e.so1});
                chk("co1", {7'd0, co1}, {7'd0, e.co1});
            end
        end
    end

    initial begin : stim
        stim_t idle;
        stim_t a, b;
        idle = mk(1'b0, 1'b0, HOLD, 8'h00, 1'b0);
        @(posedge C); #1;

        // reset visible before any edge, then a load
        step(mk(1'b1, 1'b0, HOLD, 8'h00, 1'b0), mk(1'b1, 1'b0, HOLD, 8'h00, 1'b0));
        step(mk(1'b0, 1'b1, LOAD, 8'h3C, 1'b0), idle);
        // enable gates counting
        repeat (5) step(mk(1'b0, 1'b0, CNT, 8'h00, 1'b0), idle);
        repeat (4) step(mk(1'b0, 1'b1, CNT, 8'h00, 1'b0), idle);
        // wrap from FF with CO in the cycle before
        step(mk(1'b0, 1'b1, LOAD, 8'hFE, 1'b0), idle);
        repeat (3) step(mk(1'b0, 1'b1, CNT, 8'h00, 1'b0), idle);
        // shift left
        step(mk(1'b0, 1'b1, LOAD, 8'h81, 1'b0), idle);
        step(mk(1'b0, 1'b1, SHL, 8'h00, 1'b1), idle);
        step(mk(1'b0, 1'b1, SHL, 8'h00, 1'b0), idle);
        step(idle, idle);
        // async reset in the middle of a count run
        step(mk(1'b0, 1'b1, LOAD, 8'h10, 1'b0), idle);
        repeat (3) step(mk(1'b0, 1'b1, CNT, 8'h00, 1'b0), idle);
        repeat (2) step(mk(1'b1, 1'b1, CNT, 8'h00, 1'b0), idle);
        step(mk(1'b0, 1'b1, CNT, 8'h00, 1'b0), idle);
        step(idle, idle);
        // single-bit instance with reset value 1
        step(idle, mk(1'b1, 1'b1, CNT, 8'h00, 1'b0));
        repeat (2) step(idle, mk(1'b0, 1'b1, CNT, 8'h00, 1'b0));
        step(idle, mk(1'b0, 1'b1, SHL, 8'h00, 1'b0));
        step(idle, idle);

        for (int n = 0; n < 400; n++) begin
            a = mk(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                   2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom));
            b = mk(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                   2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom));
            step(a, b);
        end
        step(idle, idle);

        repeat (3) @(negedge C);
        #1;
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
